id_ex_alu_issue: RTL and testbench
==================================

// Module: id_ex_alu_issue
// PURPOSE
// - ID/EX pipeline stage that builds and issues the ALU operation: decodes ALUOp+opcode into the 4-bit ALUControl,
//   registers operands/control, and applies EX-stage forwarding to produce the ALU's a, b and ALUControl inputs.
// - Sits between the register-file/decoder (ID) and the 64-bit ALU (EX); the ALU consumes ex_a, ex_b, ex_alucontrol.
// PARAMETERS
// - WIDTH  64  datapath width of operands, immediate and forward buses
// - OPW    11  width of instruction opcode field (instr[31:21])
// PORTS
// - clk              in   1      rising-edge clock
// - reset            in   1      asynchronous, active-high reset
// - stall            in   1      hold EX register contents (hazard unit)
// - flush            in   1      insert bubble into EX (branch taken / exception)
// - id_valid         in   1      ID stage holds a real instruction
// - id_rd1, id_rd2   in   WIDTH  register-file read data
// - id_imm           in   WIDTH  sign-extended immediate
// - id_alusrc        in   1      1: operand b = immediate, 0: b = rd2
// - id_aluop         in   2      00 mem-add, 01 pass-b (CBZ), 10 R-type, 11 reserved
// - id_opcode        in   OPW    instr[31:21]
// - fwd_a, fwd_b     in   2      00 register, 10 MEM result, 01 WB result, 11 register
// - mem_result       in   WIDTH  EX/MEM ALU result
// - wb_result        in   WIDTH  MEM/WB write-back value
// - ex_a, ex_b       out  WIDTH  ALU operands (after forwarding / alusrc)
// - ex_alucontrol    out  4      ALU operation code
// - ex_wdata         out  WIDTH  store data (forwarded rd2, independent of alusrc)
// - ex_valid         out  1      EX holds a real instruction
// - ex_illegal       out  1      decoded op unsupported (registered with instruction)
// BEHAVIOUR
// - Decode (comb, ID side): aluop 00->0010 add; 01->0111 pass b; 11->0000, illegal=1.
//   aluop 10: opcode 10001011000 ADD->0010, 11001011000 SUB->0110, 10001010000 AND->0000,
//   10101010000 ORR->0001; any other opcode ->0000, illegal=1.
// - EX register update priority: reset > flush > stall > load. Latency ID->EX exactly 1 clk.
// - Load: capture rd1, rd2, imm, alusrc, decoded control, illegal; ex_valid<=id_valid.
//   id_valid=0 loads a bubble (same as flush contents).
// - Bubble/flush: ex_valid<=0, alucontrol<=0000, illegal<=0, alusrc<=0, rd1/rd2/imm<=0.
// - flush and stall same cycle: flush wins. Stall alone: every EX register holds.
// - Reset (async, any time incl. mid-stall): all EX registers 0 -> ex_valid=0, ex_alucontrol=0000,
//   ex_illegal=0, ex_a=ex_b=ex_wdata=0 while fwd_*=00.
// - Forwarding (comb, EX side): fa = sel(fwd_a, reg rd1, mem_result, wb_result); same for fb on rd2.
//   Code 11 treated as 00. ex_a=fa; ex_wdata=fb; ex_b = alusrc ? imm : fb.
// - Forwarding applies to bubbles too; outputs are don't-care when ex_valid=0 except alucontrol=0000.
// - No width growth: all operand paths exactly WIDTH, no sign handling beyond the given immediate.
// STRUCTURE
// - Shared package alu_pkg: ALU_AND=0000, ALU_ORR=0001, ALU_ADD=0010, ALU_SUB=0110, ALU_PASSB=0111;
//   ALUOP_MEM/CBZ/RTYPE/RSVD; opcode constants OP_ADD/SUB/AND/ORR; fwd_sel_e enum.
// - Sub-module alu_control_dec (comb: aluop, opcode -> alucontrol, illegal); top holds register + fwd muxes.
// TESTING
// - R-type ADD: aluop=10, opcode=10001011000, rd1=5, rd2=7, fwd=00 -> next clk ex_alucontrol=0010, ex_a=5, ex_b=7, ex_valid=1.
// - LDUR: aluop=00, alusrc=1, rd1=0x100, imm=0x18, rd2=0xAA -> ex_b=0x18, ex_wdata=0xAA, ex_alucontrol=0010.
// - Forwarding: loaded SUB rd1=1, rd2=2; fwd_a=10 mem_result=0x40, fwd_b=01 wb_result=0x9 -> ex_a=0x40, ex_b=0x9, ctl=0110.
// - Stall 3 clks with new ID values -> EX outputs unchanged; stall+flush together -> ex_valid=0, ctl=0000.
// - Illegal: aluop=10, opcode=11111111111 -> ex_illegal=1, ctl=0000; aluop=11 -> ex_illegal=1.
// - Reset asserted mid-stall between edges -> outputs 0 immediately (async), ex_valid=0; first load after release correct.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU encodings for the ID/EX issue stage.
// Control codes, ALUOp classes, R-type opcodes and forward selects.
package alu_pkg;

   localparam logic [3:0] ALU_AND   = 4'b0000;
   localparam logic [3:0] ALU_ORR   = 4'b0001;
   localparam logic [3:0] ALU_ADD   = 4'b0010;
   localparam logic [3:0] ALU_SUB   = 4'b0110;
   localparam logic [3:0] ALU_PASSB = 4'b0111;

   localparam logic [1:0] ALUOP_MEM   = 2'b00;
   localparam logic [1:0] ALUOP_CBZ   = 2'b01;
   localparam logic [1:0] ALUOP_RTYPE = 2'b10;
   localparam logic [1:0] ALUOP_RSVD  = 2'b11;

   localparam logic [10:0] OP_ADD = 11'b10001011000;
   localparam logic [10:0] OP_SUB = 11'b11001011000;
   localparam logic [10:0] OP_AND = 11'b10001010000;
   localparam logic [10:0] OP_ORR = 11'b10101010000;

   typedef enum logic [1:0] {
      FWD_REG  = 2'b00,
      FWD_WB   = 2'b01,
      FWD_MEM  = 2'b10,
      FWD_REG2 = 2'b11
   } fwd_sel_e;

endpackage

// File: rtl/alu_control_dec.sv
// ALU control decoder: ALUOp + opcode -> 4-bit ALUControl.
// Unsupported combinations decode to AND (0000) and flag illegal.
module alu_control_dec
   import alu_pkg::*;
#(
   parameter int OPW = 11
) (
   input  logic [1:0]     aluop,
   input  logic [OPW-1:0] opcode,
   output logic [3:0]     alucontrol,
   output logic           illegal
);

   always_comb begin
      alucontrol = ALU_AND;
      illegal    = 1'b0;
      case (aluop)
         ALUOP_MEM: alucontrol = ALU_ADD;
         ALUOP_CBZ: alucontrol = ALU_PASSB;
         ALUOP_RTYPE: begin
            if (opcode == OP_ADD)      alucontrol = ALU_ADD;
            else if (opcode == OP_SUB) alucontrol = ALU_SUB;
            else if (opcode == OP_AND) alucontrol = ALU_AND;
            else if (opcode == OP_ORR) alucontrol = ALU_ORR;
            else                       illegal    = 1'b1;
         end
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/id_ex_alu_issue.sv
// ID/EX stage: decodes ALU control, holds EX operands and control,
// and forwards MEM/WB results into the ALU operand buses.
module id_ex_alu_issue
   import alu_pkg::*;
#(
   parameter int WIDTH = 64,
   parameter int OPW   = 11
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             stall,
   input  logic             flush,
   input  logic             id_valid,
   input  logic [WIDTH-1:0] id_rd1,
   input  logic [WIDTH-1:0] id_rd2,
   input  logic [WIDTH-1:0] id_imm,
   input  logic             id_alusrc,
   input  logic [1:0]       id_aluop,
   input  logic [OPW-1:0]   id_opcode,
   input  logic [1:0]       fwd_a,
   input  logic [1:0]       fwd_b,
   input  logic [WIDTH-1:0] mem_result,
   input  logic [WIDTH-1:0] wb_result,
   output logic [WIDTH-1:0] ex_a,
   output logic [WIDTH-1:0] ex_b,
   output logic [3:0]       ex_alucontrol,
   output logic [WIDTH-1:0] ex_wdata,
   output logic             ex_valid,
   output logic             ex_illegal
);

   logic [3:0]       w_ctl;
   logic             w_illegal;
   logic             w_bubble;
   logic [WIDTH-1:0] w_fa;
   logic [WIDTH-1:0] w_fb;

   logic [WIDTH-1:0] r_rd1;
   logic [WIDTH-1:0] r_rd2;
   logic [WIDTH-1:0] r_imm;
   logic             r_alusrc;
   logic [3:0]       r_ctl;
   logic             r_illegal;
   logic             r_valid;

   alu_control_dec #(.OPW(OPW)) u_dec (
      .aluop      (id_aluop),
      .opcode     (id_opcode),
      .alucontrol (w_ctl),
      .illegal    (w_illegal)
   );

   // An empty ID slot loads the same contents as a flush.
   assign w_bubble = flush || !id_valid;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rd1     <= '0;
         r_rd2     <= '0;
         r_imm     <= '0;
         r_alusrc  <= 1'b0;
         r_ctl     <= ALU_AND;
         r_illegal <= 1'b0;
         r_valid   <= 1'b0;
      end else if (w_bubble && (flush || !stall)) begin
         r_rd1     <= '0;
         r_rd2     <= '0;
         r_imm     <= '0;
         r_alusrc  <= 1'b0;
         r_ctl     <= ALU_AND;
         r_illegal <= 1'b0;
         r_valid   <= 1'b0;
      end else if (!stall) begin
         r_rd1     <= id_rd1;
         r_rd2     <= id_rd2;
         r_imm     <= id_imm;
         r_alusrc  <= id_alusrc;
         r_ctl     <= w_ctl;
         r_illegal <= w_illegal;
         r_valid   <= 1'b1;
      end
   end

   function automatic logic [WIDTH-1:0] fwd_mux(
      input logic [1:0]       sel,
      input logic [WIDTH-1:0] rf,
      input logic [WIDTH-1:0] mem,
      input logic [WIDTH-1:0] wb
   );
      case (fwd_sel_e'(sel))
         FWD_MEM: fwd_mux = mem;
         FWD_WB:  fwd_mux = wb;
         default: fwd_mux = rf;
      endcase
   endfunction

   assign w_fa = fwd_mux(fwd_a, r_rd1, mem_result, wb_result);
   assign w_fb = fwd_mux(fwd_b, r_rd2, mem_result, wb_result);

   assign ex_a          = w_fa;
   assign ex_b          = r_alusrc ? r_imm : w_fb;
   assign ex_wdata      = w_fb;
   assign ex_alucontrol = r_ctl;
   assign ex_valid      = r_valid;
   assign ex_illegal    = r_illegal;

endmodule

// File: tb/tb_id_ex_alu_issue.sv
// Directed bench for id_ex_alu_issue with an expected-value queue.
module tb_id_ex_alu_issue;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall;
   logic        flush;
   logic        id_valid;
   logic [63:0] id_rd1;
   logic [63:0] id_rd2;
   logic [63:0] id_imm;
   logic        id_alusrc;
   logic [1:0]  id_aluop;
   logic [10:0] id_opcode;
   logic [1:0]  fwd_a;
   logic [1:0]  fwd_b;
   logic [63:0] mem_result;
   logic [63:0] wb_result;
   logic [63:0] ex_a;
   logic [63:0] ex_b;
   logic [3:0]  ex_alucontrol;
   logic [63:0] ex_wdata;
   logic        ex_valid;
   logic        ex_illegal;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string       tag;
      logic [63:0] a;
      logic [63:0] b;
      logic [63:0] wd;
      logic [3:0]  ctl;
      logic        v;
      logic        ill;
   } exp_t;

   exp_t sb[$];

   id_ex_alu_issue #(.WIDTH(64), .OPW(11)) dut (
      .clk           (clk),
      .reset         (reset),
      .stall         (stall),
      .flush         (flush),
      .id_valid      (id_valid),
      .id_rd1        (id_rd1),
      .id_rd2        (id_rd2),
      .id_imm        (id_imm),
      .id_alusrc     (id_alusrc),
      .id_aluop      (id_aluop),
      .id_opcode     (id_opcode),
      .fwd_a         (fwd_a),
      .fwd_b         (fwd_b),
      .mem_result    (mem_result),
      .wb_result     (wb_result),
      .ex_a          (ex_a),
      .ex_b          (ex_b),
      .ex_alucontrol (ex_alucontrol),
      .ex_wdata      (ex_wdata),
      .ex_valid      (ex_valid),
      .ex_illegal    (ex_illegal)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout, expected finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic push(input string tag, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] wd,
                       input logic [3:0] ctl, input logic v,
                       input logic ill);
      exp_t e;
      e.tag = tag; e.a = a; e.b = b; e.wd = wd;
      e.ctl = ctl; e.v = v; e.ill = ill;
      sb.push_back(e);
   endtask

   task automatic pop_check();
      exp_t e;
      checks++;
      assert (sb.size() != 0) else begin
         errors++;
         $error("FAIL scoreboard observed=empty expected=entry");
      end
      if (sb.size() != 0) begin
         e = sb.pop_front();
         chk({e.tag, ".a"},   ex_a, e.a);
         chk({e.tag, ".b"},   ex_b, e.b);
         chk({e.tag, ".wd"},  ex_wdata, e.wd);
         chk({e.tag, ".ctl"}, {60'd0, ex_alucontrol}, {60'd0, e.ctl});
         chk({e.tag, ".v"},   {63'd0, ex_valid}, {63'd0, e.v});
         chk({e.tag, ".ill"}, {63'd0, ex_illegal}, {63'd0, e.ill});
      end
   endtask

   task automatic drive(input logic v, input logic [1:0] op,
                        input logic [10:0] opc, input logic src,
                        input logic [63:0] r1, input logic [63:0] r2,
                        input logic [63:0] imm);
      id_valid = v; id_aluop = op; id_opcode = opc;
      id_alusrc = src; id_rd1 = r1; id_rd2 = r2; id_imm = imm;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      pop_check();
   endtask

   initial begin
      reset = 1'b1; stall = 1'b0; flush = 1'b0;
      fwd_a = 2'b00; fwd_b = 2'b00;
      mem_result = 64'hDEAD; wb_result = 64'hBEEF;
      drive(1'b1, 2'b10, 11'b10001011000, 1'b0, 64'd9, 64'd9, 64'd9);
      push("reset", 0, 0, 0, 4'b0000, 0, 0);
      step();
      reset = 1'b0;

      drive(1'b1, 2'b10, 11'b10001011000, 1'b0, 64'd5, 64'd7, 64'd0);
      push("add", 64'd5, 64'd7, 64'd7, 4'b0010, 1, 0);
      step();

      drive(1'b1, 2'b00, 11'b11111000010, 1'b1, 64'h100, 64'hAA, 64'h18);
      push("ldur", 64'h100, 64'h18, 64'hAA, 4'b0010, 1, 0);
      step();

      drive(1'b1, 2'b10, 11'b11001011000, 1'b0, 64'd1, 64'd2, 64'd0);
      push("sub", 64'd1, 64'd2, 64'd2, 4'b0110, 1, 0);
      step();
      fwd_a = 2'b10; fwd_b = 2'b01;
      mem_result = 64'h40; wb_result = 64'h9;
      #1;
      push("fwd", 64'h40, 64'h9, 64'h9, 4'b0110, 1, 0);
      pop_check();
      fwd_a = 2'b11; fwd_b = 2'b11;
      #1;
      push("fwd11", 64'd1, 64'd2, 64'd2, 4'b0110, 1, 0);
      pop_check();
      fwd_a = 2'b00; fwd_b = 2'b00;

      drive(1'b1, 2'b10, 11'b10001010000, 1'b0, 64'hF0, 64'h3C, 64'h0);
      push("and", 64'hF0, 64'h3C, 64'h3C, 4'b0000, 1, 0);
      step();

      drive(1'b1, 2'b01, 11'b10110100000, 1'b0, 64'h0, 64'h55, 64'h8);
      push("cbz", 64'h0, 64'h55, 64'h55, 4'b0111, 1, 0);
      step();

      drive(1'b1, 2'b10, 11'b10101010000, 1'b0, 64'h11, 64'h22, 64'h0);
      push("orr", 64'h11, 64'h22, 64'h22, 4'b0001, 1, 0);
      step();

      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 2'b10, 11'b11001011000, 1'b1,
               64'h777 + i, 64'h888, 64'h999);
         push("stall", 64'h11, 64'h22, 64'h22, 4'b0001, 1, 0);
         step();
      end

      flush = 1'b1;
      push("stflush", 0, 0, 0, 4'b0000, 0, 0);
      step();
      stall = 1'b0; flush = 1'b0;

      drive(1'b1, 2'b10, 11'b11111111111, 1'b0, 64'h3, 64'h4, 64'h0);
      push("illop", 64'h3, 64'h4, 64'h4, 4'b0000, 1, 1);
      step();

      drive(1'b1, 2'b11, 11'b10001011000, 1'b0, 64'h6, 64'h5, 64'h0);
      push("rsvd", 64'h6, 64'h5, 64'h5, 4'b0000, 1, 1);
      step();

      drive(1'b0, 2'b10, 11'b10001011000, 1'b0, 64'h6, 64'h5, 64'h0);
      push("novalid", 0, 0, 0, 4'b0000, 0, 0);
      step();

      drive(1'b1, 2'b10, 11'b10001011000, 1'b0, 64'h3, 64'h4, 64'h0);
      push("add2", 64'h3, 64'h4, 64'h4, 4'b0010, 1, 0);
      step();
      stall = 1'b1;
      #2;
      reset = 1'b1;
      #1;
      push("asyncrst", 0, 0, 0, 4'b0000, 0, 0);
      pop_check();
      #1;
      reset = 1'b0;
      push("rsthold", 0, 0, 0, 4'b0000, 0, 0);
      step();
      stall = 1'b0;

      drive(1'b1, 2'b10, 11'b11001011000, 1'b0, 64'h9, 64'h4, 64'h0);
      push("postrst", 64'h9, 64'h4, 64'h4, 4'b0110, 1, 0);
      step();

      drive(1'b1, 2'b00, 11'b11111000000, 1'b1, 64'h20, 64'h30, 64'h8);
      flush = 1'b1;
      push("flush", 0, 0, 0, 4'b0000, 0, 0);
      step();
      flush = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
